// File: rtl/cpu_pkg.sv
// Shared types and constants for the 8-bit processor core.
// Field positions, opcode encodings and fetch-stage control bundles.
package cpu_pkg;

  localparam int INSTR_W = 16;

  localparam int OPC_HI  = 15;
  localparam int OPC_LO  = 12;
  localparam int FUNC_HI = 2;
  localparam int FUNC_LO = 0;

  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_ADDI  = 4'b0100;
  localparam logic [3:0] OP_LW    = 4'b1011;
  localparam logic [3:0] OP_SW    = 4'b1111;
  localparam logic [3:0] OP_CMP   = 4'b1000;
  localparam logic [3:0] OP_J     = 4'b0010;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    HOLD,
    HALTED
  } fetch_state_t;

  typedef struct packed {
    logic load;
    logic take;
    logic inc;
    logic arm;
    logic disarm;
  } pc_ctl_t;

endpackage

// File: rtl/fetch_pc.sv
// Fetch program counter with increment, redirect load
// and a parked squash target for redirects during a pending fetch.
module fetch_pc
  import cpu_pkg::*;
#(
  parameter int          PC_W     = 8,
  parameter int unsigned RESET_PC = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  pc_ctl_t         ctl,
  input  logic [PC_W-1:0] redirect_pc,
  output logic [PC_W-1:0] pc,
  output logic            squash
);

  logic [PC_W-1:0] tgt;
  logic [PC_W-1:0] pc_d;

  // load/take/inc are mutually exclusive by construction
  always_comb begin
    pc_d = pc;
    unique case (1'b1)
      ctl.load: pc_d = redirect_pc;
      ctl.take: pc_d = tgt;
      ctl.inc:  pc_d = pc + PC_W'(1);
      default:  pc_d = pc;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= PC_W'(RESET_PC);
    end else begin
      pc <= pc_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tgt    <= '0;
      squash <= 1'b0;
    end else if (ctl.arm) begin
      tgt    <= redirect_pc;
      squash <= 1'b1;
    end else if (ctl.disarm) begin
      squash <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, imem req/ack port, IR and
// valid/ready handoff to decode with redirect squashing.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int          PC_W     = 8,
  parameter int          INSTR_W  = cpu_pkg::INSTR_W,
  parameter int unsigned RESET_PC = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [3:0]         opcode,
  output logic [2:0]         func,
  output logic [PC_W-1:0]    instr_pc,
  input  logic               redirect_en,
  input  logic [PC_W-1:0]    redirect_pc,
  input  logic               halt
);

  fetch_state_t       state;
  fetch_state_t       nstate;
  pc_ctl_t            ctl;
  logic               ir_load;
  logic               squash;
  logic [PC_W-1:0]    pc;
  logic [INSTR_W-1:0] ir;

  fetch_pc #(
    .PC_W     (PC_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk         (clk),
    .rst_n       (rst_n),
    .ctl         (ctl),
    .redirect_pc (redirect_pc),
    .pc          (pc),
    .squash      (squash)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= nstate;
    end
  end

  always_comb begin
    nstate      = state;
    ctl         = '0;
    ir_load     = 1'b0;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    unique case (state)
      IDLE: begin
        if (redirect_en) begin
          ctl.load = 1'b1;
          nstate   = REQ;
        end else begin
          nstate = halt ? HALTED : REQ;
        end
      end
      REQ: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ctl.disarm = 1'b1;
          if (redirect_en) begin
            ctl.load = 1'b1;
          end else if (squash) begin
            ctl.take = 1'b1;
          end else begin
            ctl.inc = 1'b1;
            ir_load = 1'b1;
            nstate  = HOLD;
          end
        end else if (redirect_en) begin
          // address must stay put until ack; park the target
          ctl.arm = 1'b1;
        end
      end
      HOLD: begin
        instr_valid = !redirect_en;
        if (redirect_en) begin
          ctl.load = 1'b1;
          nstate   = REQ;
        end else if (instr_ready) begin
          nstate = halt ? HALTED : REQ;
        end
      end
      HALTED: begin
        if (redirect_en) begin
          ctl.load = 1'b1;
          nstate   = REQ;
        end
      end
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir       <= '0;
      instr_pc <= '0;
    end else if (ir_load) begin
      ir       <= imem_rdata;
      instr_pc <= pc;
    end
  end

  assign imem_addr = pc;
  assign instr     = ir;
  assign opcode    = ir[OPC_HI:OPC_LO];
  assign func      = ir[FUNC_HI:FUNC_LO];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a simple
// wait-state instruction memory model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [3:0]  opcode;
  logic [2:0]  func;
  logic [7:0]  instr_pc;
  logic        redirect_en;
  logic [7:0]  redirect_pc;
  logic        halt;

  int n_cmp = 0;
  int n_bad = 0;
  int lat   = 0;
  int wcnt  = 0;

  fetch_unit #(
    .PC_W     (8),
    .INSTR_W  (16),
    .RESET_PC (0)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .opcode      (opcode),
    .func        (func),
    .instr_pc    (instr_pc),
    .redirect_en (redirect_en),
    .redirect_pc (redirect_pc),
    .halt        (halt)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] img(input logic [7:0] a);
    return 16'h4105 ^ {a, a};
  endfunction

  // advance one cycle, then let memory answer the current request
  task automatic step();
    @(posedge clk);
    #1;
    if (imem_req && wcnt >= lat) begin
      imem_ack   = 1'b1;
      imem_rdata = img(imem_addr);
      wcnt       = 0;
    end else begin
      imem_ack   = 1'b0;
      imem_rdata = 16'hDEAD;
      wcnt       = imem_req ? wcnt + 1 : 0;
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0; imem_ack = 0; imem_rdata = 16'hDEAD;
    instr_ready = 0; redirect_en = 0; redirect_pc = 0; halt = 0;
    step(); step();
    n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL rst_req: got %b want 0", imem_req); end
    n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", instr_valid); end
    n_cmp++; if (instr !== 16'h0) begin n_bad++; $display("FAIL rst_instr: got %h want 0000", instr); end
    n_cmp++; if (opcode !== 4'h0 || func !== 3'h0) begin n_bad++; $display("FAIL rst_fields: got %h/%h want 0/0", opcode, func); end
    n_cmp++; if (instr_pc !== 8'h0) begin n_bad++; $display("FAIL rst_ipc: got %h want 00", instr_pc); end
    n_cmp++; if (imem_addr !== 8'h0) begin n_bad++; $display("FAIL rst_addr: got %h want 00", imem_addr); end
    rst_n = 1; instr_ready = 1;
    #1;
    n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL idle_req: got %b want 0", imem_req); end
    step();
    n_cmp++; if (imem_req !== 1'b1) begin n_bad++; $display("FAIL first_req: got %b want 1", imem_req); end
  endtask

  task automatic test_stream();
    logic [15:0] exp [3];
    exp[0] = 16'h4105; exp[1] = 16'h4004; exp[2] = 16'h4307;
    for (int k = 0; k < 3; k++) begin
      n_cmp++; if (imem_addr !== 8'(k)) begin n_bad++; $display("FAIL str_addr%0d: got %h want %h", k, imem_addr, 8'(k)); end
      n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL str_novalid%0d: got %b want 0", k, instr_valid); end
      step();
      n_cmp++; if (instr_valid !== 1'b1) begin n_bad++; $display("FAIL str_valid%0d: got %b want 1", k, instr_valid); end
      n_cmp++; if (instr !== exp[k]) begin n_bad++; $display("FAIL str_instr%0d: got %h want %h", k, instr, exp[k]); end
      n_cmp++; if (instr_pc !== 8'(k)) begin n_bad++; $display("FAIL str_ipc%0d: got %h want %h", k, instr_pc, 8'(k)); end
      n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL str_noreq%0d: got %b want 0", k, imem_req); end
      if (k == 0) begin
        n_cmp++; if (opcode !== 4'b0100) begin n_bad++; $display("FAIL str_opcode: got %b want 0100", opcode); end
        n_cmp++; if (func !== 3'b101) begin n_bad++; $display("FAIL str_func: got %b want 101", func); end
      end
      if (k < 2) step();
    end
  endtask

  task automatic test_stall();
    instr_ready = 0;
    repeat (5) begin
      step();
      n_cmp++; if (instr_valid !== 1'b1) begin n_bad++; $display("FAIL stall_valid: got %b want 1", instr_valid); end
      n_cmp++; if (instr !== 16'h4307) begin n_bad++; $display("FAIL stall_instr: got %h want 4307", instr); end
      n_cmp++; if (instr_pc !== 8'h02) begin n_bad++; $display("FAIL stall_ipc: got %h want 02", instr_pc); end
      n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL stall_req: got %b want 0", imem_req); end
    end
    instr_ready = 1;
    step();
    n_cmp++; if (imem_addr !== 8'h03) begin n_bad++; $display("FAIL stall_next: got %h want 03", imem_addr); end
    step(); step(); step();
    lat = 3;
    step();
  endtask

  task automatic test_redirect_req();
    redirect_en = 1; redirect_pc = 8'h40;
    #1;
    n_cmp++; if (imem_addr !== 8'h05) begin n_bad++; $display("FAIL sq_addr0: got %h want 05", imem_addr); end
    for (int i = 0; i < 3; i++) begin
      step();
      redirect_en = 0;
      n_cmp++; if (imem_addr !== 8'h05 || imem_req !== 1'b1) begin n_bad++; $display("FAIL sq_hold%0d: got %h/%b want 05/1", i, imem_addr, imem_req); end
      n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL sq_novalid%0d: got %b want 0", i, instr_valid); end
    end
    lat = 0;
    step();
    n_cmp++; if (imem_addr !== 8'h40) begin n_bad++; $display("FAIL sq_target: got %h want 40", imem_addr); end
    n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL sq_drop: got %b want 0", instr_valid); end
    step();
    n_cmp++; if (instr_pc !== 8'h40 || instr !== 16'h0145) begin n_bad++; $display("FAIL sq_land: got %h/%h want 40/0145", instr_pc, instr); end
  endtask

  task automatic test_redirect_hold();
    redirect_en = 1; redirect_pc = 8'h10;
    #1;
    n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL hold_kill: got %b want 0", instr_valid); end
    step();
    redirect_en = 0;
    n_cmp++; if (imem_addr !== 8'h10 || imem_req !== 1'b1) begin n_bad++; $display("FAIL hold_addr: got %h/%b want 10/1", imem_addr, imem_req); end
    step();
    n_cmp++; if (instr_pc !== 8'h10 || instr !== 16'h5115) begin n_bad++; $display("FAIL hold_land: got %h/%h want 10/5115", instr_pc, instr); end
  endtask

  task automatic test_wrap();
    redirect_en = 1; redirect_pc = 8'hFF;
    step();
    redirect_en = 0;
    n_cmp++; if (imem_addr !== 8'hFF) begin n_bad++; $display("FAIL wrap_ff: got %h want ff", imem_addr); end
    step();
    n_cmp++; if (instr_pc !== 8'hFF || instr !== 16'hBEFA) begin n_bad++; $display("FAIL wrap_ir: got %h/%h want ff/befa", instr_pc, instr); end
    step();
    n_cmp++; if (imem_addr !== 8'h00) begin n_bad++; $display("FAIL wrap_00: got %h want 00", imem_addr); end
  endtask

  task automatic test_redirect_ack();
    redirect_en = 1; redirect_pc = 8'h30;
    step();
    redirect_en = 0;
    n_cmp++; if (imem_addr !== 8'h30 || imem_req !== 1'b1) begin n_bad++; $display("FAIL rack_addr: got %h/%b want 30/1", imem_addr, imem_req); end
    n_cmp++; if (instr_valid !== 1'b0 || instr !== 16'hBEFA) begin n_bad++; $display("FAIL rack_drop: got %b/%h want 0/befa", instr_valid, instr); end
    step();
    n_cmp++; if (instr_pc !== 8'h30 || instr !== 16'h7135) begin n_bad++; $display("FAIL rack_land: got %h/%h want 30/7135", instr_pc, instr); end
  endtask

  task automatic test_halt();
    halt = 1;
    #1;
    n_cmp++; if (instr_valid !== 1'b1) begin n_bad++; $display("FAIL halt_fire: got %b want 1", instr_valid); end
    step();
    halt = 0;
    n_cmp++; if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin n_bad++; $display("FAIL halt_enter: got %b/%b want 0/0", imem_req, instr_valid); end
    repeat (3) begin
      step();
      n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL halt_stay: got %b want 0", imem_req); end
    end
    redirect_en = 1; redirect_pc = 8'h20; lat = 5;
    step();
    redirect_en = 0;
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 8'h20) begin n_bad++; $display("FAIL halt_resume: got %b/%h want 1/20", imem_req, imem_addr); end
  endtask

  task automatic test_reset_mid();
    #2;
    rst_n = 0;
    #1;
    n_cmp++; if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin n_bad++; $display("FAIL mid_ctl: got %b/%b want 0/0", imem_req, instr_valid); end
    n_cmp++; if (instr !== 16'h0 || instr_pc !== 8'h0) begin n_bad++; $display("FAIL mid_ir: got %h/%h want 0000/00", instr, instr_pc); end
    n_cmp++; if (opcode !== 4'h0 || func !== 3'h0 || imem_addr !== 8'h0) begin n_bad++; $display("FAIL mid_misc: got %h/%h/%h want 0/0/00", opcode, func, imem_addr); end
    step();
    rst_n = 1;
    step();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect_req();
    test_redirect_hold();
    test_wrap();
    test_redirect_ack();
    test_halt();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
